// File: rtl/axi_aw_w_lock_mux.sv
// Write-path lock mux: forwards the arbiter winner's AW beat and then its full W burst
// to a single slave port, holding the selection until WLAST and flagging length mismatches.
module axi_aw_w_lock_mux #(
  parameter int  NumMasters = 4,
  parameter int  AddrWidth  = 32,
  parameter int  IdWidth    = 4,
  parameter int  DataWidth  = 32,
  localparam int BinWidth   = (NumMasters > 1) ? $clog2(NumMasters) : 1,
  localparam int StrbWidth  = DataWidth / 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  output logic [NumMasters-1:0]           arb_req_o,
  input  logic [NumMasters-1:0]           arb_grant_i,
  input  logic [BinWidth-1:0]             arb_bin_grant_i,
  input  logic [NumMasters-1:0]           s_awvalid_i,
  output logic [NumMasters-1:0]           s_awready_o,
  input  logic [NumMasters*AddrWidth-1:0] s_awaddr_i,
  input  logic [NumMasters*IdWidth-1:0]   s_awid_i,
  input  logic [NumMasters*8-1:0]         s_awlen_i,
  input  logic [NumMasters-1:0]           s_wvalid_i,
  output logic [NumMasters-1:0]           s_wready_o,
  input  logic [NumMasters*DataWidth-1:0] s_wdata_i,
  input  logic [NumMasters*StrbWidth-1:0] s_wstrb_i,
  input  logic [NumMasters-1:0]           s_wlast_i,
  output logic                            m_awvalid_o,
  output logic [AddrWidth-1:0]            m_awaddr_o,
  output logic [IdWidth-1:0]              m_awid_o,
  output logic [7:0]                      m_awlen_o,
  input  logic                            m_awready_i,
  output logic                            m_wvalid_o,
  output logic [DataWidth-1:0]            m_wdata_o,
  output logic [StrbWidth-1:0]            m_wstrb_o,
  output logic                            m_wlast_o,
  input  logic                            m_wready_i,
  output logic [BinWidth-1:0]             sel_o,
  output logic                            busy_o,
  output logic                            len_err_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BinWidth-1:0]  r_sel;
  logic [7:0]           r_len;
  logic [8:0]           r_cnt;
  logic                 r_len_err;

  logic [AddrWidth-1:0] w_awaddr [NumMasters];
  logic [IdWidth-1:0]   w_awid   [NumMasters];
  logic [7:0]           w_awlen  [NumMasters];
  logic [DataWidth-1:0] w_wdata  [NumMasters];
  logic [StrbWidth-1:0] w_wstrb  [NumMasters];

  logic                 w_grant;
  logic                 w_w_hs;
  logic                 w_len_bad;

  for (genvar gi = 0; gi < NumMasters; gi++) begin : g_unpack
    assign w_awaddr[gi] = s_awaddr_i[gi*AddrWidth +: AddrWidth];
    assign w_awid[gi]   = s_awid_i[gi*IdWidth +: IdWidth];
    assign w_awlen[gi]  = s_awlen_i[gi*8 +: 8];
    assign w_wdata[gi]  = s_wdata_i[gi*DataWidth +: DataWidth];
    assign w_wstrb[gi]  = s_wstrb_i[gi*StrbWidth +: StrbWidth];
  end

  // Payload is always steered by the registered select; only valid/ready are state-gated.
  assign m_awaddr_o = w_awaddr[r_sel];
  assign m_awid_o   = w_awid[r_sel];
  assign m_awlen_o  = w_awlen[r_sel];
  assign m_wdata_o  = w_wdata[r_sel];
  assign m_wstrb_o  = w_wstrb[r_sel];
  assign m_wlast_o  = s_wlast_i[r_sel];

  assign sel_o     = r_sel;
  assign busy_o    = (r_state != ST_IDLE);
  assign len_err_o = r_len_err;

  assign w_grant   = (r_state == ST_IDLE) && (|arb_grant_i);
  assign w_w_hs    = m_wvalid_o && m_wready_i;
  assign w_len_bad = m_wlast_o ? (r_cnt != {1'b0, r_len}) : (r_cnt == {1'b0, r_len});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    arb_req_o   = '0;
    s_awready_o = '0;
    s_wready_o  = '0;
    m_awvalid_o = 1'b0;
    m_wvalid_o  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        arb_req_o = s_awvalid_i;
        if (|arb_grant_i) begin
          w_state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_awvalid_o        = s_awvalid_i[r_sel];
        s_awready_o[r_sel] = m_awready_i;
        if (s_awvalid_i[r_sel] && m_awready_i) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        m_wvalid_o        = s_wvalid_i[r_sel];
        s_wready_o[r_sel] = m_wready_i;
        if (s_wvalid_i[r_sel] && m_wready_i && s_wlast_i[r_sel]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The burst always ends on WLAST; a count/length disagreement only raises the sticky flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel     <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_len_err <= 1'b0;
    end else begin
      if (w_grant) begin
        r_sel <= arb_bin_grant_i;
        r_len <= w_awlen[arb_bin_grant_i];
        r_cnt <= '0;
      end
      if (w_w_hs) begin
        r_cnt <= r_cnt + 9'd1;
        if (w_len_bad) begin
          r_len_err <= 1'b1;
        end
      end
    end
  end

endmodule
